// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, material weights, colours and register map shared by board scoring logic
package chess_pkg;
  localparam int WEIGHT_W = 16;
  typedef enum logic signed [7:0] {
    EMPTY  = 8'sd0,
    PAWN   = 8'sd1,
    KNIGHT = 8'sd2,
    BISHOP = 8'sd3,
    ROOK   = 8'sd4,
    QUEEN  = 8'sd5,
    KING   = 8'sd6
  } piece_t;
  localparam logic signed [1:0] WHITE = 2'sb01;
  localparam logic signed [1:0] BLACK = 2'sb11;
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_BASE   = 4'd1;
  localparam logic [3:0] REG_COUNT  = 4'd2;
  localparam logic [3:0] REG_COLOUR = 4'd3;
  localparam logic signed [WEIGHT_W-1:0] WEIGHTS [0:7] = '{
    16'sd0, 16'sd1, 16'sd3, 16'sd3, 16'sd5, 16'sd9, 16'sd100, 16'sd0
  };
  // Negative codes are black pieces and count against white; unknown codes weigh nothing.
  function automatic logic signed [WEIGHT_W-1:0] piece_weight(input logic signed [7:0] p);
    logic [7:0] mag;
    logic signed [WEIGHT_W-1:0] w;
    mag = p[7] ? -p : p;
    w = mag > 8'(KING) ? '0 : WEIGHTS[mag[2:0]];
    return p[7] ? -w : w;
  endfunction
endpackage

// File: rtl/material_acc.sv
// material_acc: signed accumulator with synchronous clear that saturates symmetrically
module material_acc #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] delta,
  output logic signed [W-1:0] acc
);
  localparam logic signed [W:0] MAXV = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] MINV = -MAXV;
  logic signed [W:0] sum;
  logic signed [W-1:0] nxt;
  always_comb begin
    sum = {acc[W-1], acc} + {delta[W-1], delta};
    nxt = sum > MAXV ? MAXV[W-1:0] : sum < MINV ? MINV[W-1:0] : sum[W-1:0];
  end
  always_ff @(posedge clk) acc <= !rst_n || clr ? '0 : en ? nxt : acc;
endmodule

// File: rtl/board_evaluator.sv
// board_evaluator: reads N 64-square boards from SDRAM, scores each by material
// and reports the index and score of the best board for the side to move.
module board_evaluator import chess_pkg::*; #(
  parameter int SCORE_W    = 16,
  parameter int MAX_BOARDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid
);
  localparam int NB_W = $clog2(MAX_BOARDS + 1);
  typedef enum logic [2:0] {IDLE, INIT, RD_REQ, RD_WAIT, CMP, DONE} state_t;
  state_t state;
  logic [31:0] base, best_idx;
  logic [NB_W-1:0] nboards, b;
  logic [5:0] sq;
  logic signed [1:0] colour;
  logic signed [SCORE_W-1:0] best_score, acc;
  logic busy, better, unused;
  assign busy = state != IDLE;
  assign slave_waitrequest = busy & (slave_read | slave_write);
  assign slave_readdata = slave_address == REG_CTRL  ? best_idx :
                          slave_address == REG_BASE  ? {{(32-SCORE_W){best_score[SCORE_W-1]}}, best_score} :
                          slave_address == REG_COUNT ? {31'b0, busy} : '0;
  // The first board always wins; later boards must be strictly better, so ties keep the lower index.
  assign better = b == '0 || (colour == BLACK ? acc < best_score : acc > best_score);
  assign unused = ^master_readdata[31:8];
  function automatic logic [31:0] addr_of(input logic [NB_W-1:0] bi, input logic [5:0] si);
    return base + 32'({bi, si, 2'b00});
  endfunction
  material_acc #(.W(SCORE_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == INIT || state == CMP),
    .en    (state == RD_WAIT && master_readdatavalid),
    .delta (SCORE_W'(piece_weight(master_readdata[7:0]))),
    .acc   (acc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      master_read    <= 1'b0;
      master_address <= '0;
      best_idx       <= '1;
      best_score     <= '0;
      base           <= '0;
      nboards        <= '0;
      colour         <= WHITE;
      b              <= '0;
      sq             <= '0;
    end else begin
      case (state)
        IDLE: if (slave_write) begin
          if (slave_address == REG_BASE) base <= slave_writedata;
          if (slave_address == REG_COUNT)
            nboards <= slave_writedata > 32'(MAX_BOARDS) ? NB_W'(MAX_BOARDS) : slave_writedata[NB_W-1:0];
          if (slave_address == REG_COLOUR) colour <= $signed(slave_writedata) < 0 ? BLACK : WHITE;
          if (slave_address == REG_CTRL) state <= INIT;
        end
        INIT: begin
          b              <= '0;
          sq             <= '0;
          best_idx       <= '1;
          best_score     <= '0;
          master_address <= base;
          master_read    <= nboards != '0;
          state          <= nboards == '0 ? DONE : RD_REQ;
        end
        RD_REQ: if (!master_waitrequest) begin
          master_read <= 1'b0;
          state       <= RD_WAIT;
        end
        RD_WAIT: if (master_readdatavalid) begin
          sq             <= sq + 6'd1;
          master_read    <= sq != 6'd63;
          master_address <= addr_of(b, sq + 6'd1);
          state          <= sq == 6'd63 ? CMP : RD_REQ;
        end
        CMP: begin
          if (better) begin
            best_idx   <= 32'(b);
            best_score <= acc;
          end
          b              <= b + 1'b1;
          sq             <= '0;
          master_read    <= b + 1'b1 != nboards;
          master_address <= addr_of(b + 1'b1, 6'd0);
          state          <= b + 1'b1 == nboards ? DONE : RD_REQ;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_evaluator.sv
// tb_board_evaluator: table vectors, randomized boards and memory timing against a material model
module tb_board_evaluator;
  import chess_pkg::*;
  localparam int MEMW  = 256 * 64;
  localparam int LIMIT = 40000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slave_waitrequest, slave_read, slave_write;
  logic [3:0] slave_address;
  logic [31:0] slave_readdata, slave_writedata;
  logic master_waitrequest, master_read, master_readdatavalid;
  logic [31:0] master_address, master_readdata;
  always #5 clk = ~clk;
  board_evaluator dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );
  logic signed [7:0] mem [0:MEMW-1];
  int tests = 0;
  int fails = 0;
  logic [31:0] cur_base = 0;
  int acc_cnt = 0;
  int run_start = 0;
  bit rnd_mode = 0;
  typedef struct {
    int n;
    int col;
    int s0;
    int s1;
    int s2;
    logic [31:0] eidx;
    logic [31:0] escore;
  } vec_t;
  vec_t vecs [7];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Initial chess position, optionally with one material change giving a known score.
  task automatic init_board(input int bi, input int kind);
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int v;
    for (int q = 0; q < 64; q++) begin
      v = q < 8 ? back[q] : q < 16 ? 1 : q < 48 ? 0 : q < 56 ? -1 : -back[q-56];
      mem[bi*64+q] = 8'(v);
    end
    if (kind == 3) mem[bi*64+57] = 8'sd0;
    if (kind == 1) mem[bi*64+48] = 8'sd0;
    if (kind == -5) mem[bi*64] = 8'sd0;
    if (kind == -2) begin
      mem[bi*64+8] = 8'sd0;
      mem[bi*64+9] = 8'sd0;
    end
  endtask
  function automatic void model(input int n, input int col, output logic [31:0] idx, output logic [31:0] sc);
    int wt [7] = '{0, 1, 3, 3, 5, 9, 100};
    int best, s, p, m;
    best = 0;
    idx = 32'hFFFF_FFFF;
    for (int bi = 0; bi < n; bi++) begin
      s = 0;
      for (int q = 0; q < 64; q++) begin
        p = int'(mem[bi*64+q]);
        m = p < 0 ? -p : p;
        s += m > 6 ? 0 : (p < 0 ? -wt[m] : wt[m]);
        if (s > 32767) s = 32767;
        if (s < -32767) s = -32767;
      end
      if (bi == 0 || (col < 0 ? s < best : s > best)) begin
        best = s;
        idx = bi;
      end
    end
    sc = best;
  endfunction
  task automatic cpu(input bit wr, input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd, output int cyc);
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = wr;
    slave_read = !wr;
    cyc = 0;
    #1;
    while (slave_waitrequest && cyc < LIMIT) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= LIMIT) check("cpu_timeout", 32'(cyc), 0);
    rd = slave_readdata;
    @(posedge clk);
    #1;
    slave_write = 0;
    slave_read = 0;
  endtask
  task automatic run(input int n, input int col, input logic [31:0] bs, output logic [31:0] idx, output logic [31:0] sc, output int cyc);
    logic [31:0] rd;
    int c, nn;
    nn = n > 256 ? 256 : n;
    cpu(1, REG_BASE, bs, rd, c);
    check("idle_write_zero_wait", 32'(c), 0);
    cpu(1, REG_COUNT, 32'(n), rd, c);
    cpu(1, REG_COLOUR, 32'(col), rd, c);
    cur_base = bs;
    run_start = acc_cnt;
    cpu(1, REG_CTRL, 32'h0, rd, c);
    cpu(0, REG_CTRL, 32'h0, idx, cyc);
    cpu(0, REG_BASE, 32'h0, sc, c);
    cpu(0, REG_COUNT, 32'h0, rd, c);
    check("busy_after_run", rd, 0);
    check("read_count", 32'(acc_cnt - run_start), 32'(nn * 64));
    if (nn > 0) check("latency_floor", 32'(cyc >= nn * 128), 1);
  endtask
  // SDRAM model: optional request stalls and return delays, checking addresses as they are accepted.
  initial begin
    int stall, dly;
    bit pending, armed;
    logic [31:0] hold, paddr, off, r;
    stall = 0;
    dly = 0;
    pending = 0;
    armed = 0;
    hold = 0;
    paddr = 0;
    master_waitrequest = 0;
    master_readdatavalid = 0;
    master_readdata = 0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 0;
      master_waitrequest = 0;
      if (!rst_n) begin
        pending = 0;
        armed = 0;
      end else if (pending) begin
        if (dly > 1) dly--;
        else begin
          pending = 0;
          master_readdatavalid = 1;
          r = $urandom();
          off = (paddr - cur_base) >> 2;
          tests++;
          if (off < MEMW) master_readdata = {r[31:8], mem[off]};
          else begin
            fails++;
            $display("FAIL addr_range: offset %0d not below %0d", off, MEMW);
            master_readdata = {r[31:8], 8'h00};
          end
        end
      end else if (master_read) begin
        if (!armed) begin
          armed = 1;
          hold = master_address;
          stall = rnd_mode ? int'($urandom_range(0, 4)) : 0;
        end
        check("req_addr_stable", master_address, hold);
        if (stall > 0) begin
          stall--;
          master_waitrequest = 1;
        end else begin
          armed = 0;
          pending = 1;
          dly = rnd_mode ? int'($urandom_range(1, 6)) : 1;
          paddr = master_address;
          check("req_addr", master_address, cur_base + 32'(4 * (acc_cnt - run_start)));
          acc_cnt++;
        end
      end
    end
  end
  initial begin
    logic [31:0] idx, sc, eidx, esc, rd, bs, r;
    int cyc, c, n, col, cnt;
    int cols [5] = '{1, -1, 0, 7, -3};
    slave_address = 0;
    slave_read = 0;
    slave_write = 0;
    slave_writedata = 0;
    vecs[0] = '{1, 1, 0, 0, 0, 32'h0, 32'h0};
    vecs[1] = '{3, 1, 0, 3, 3, 32'h1, 32'h3};
    vecs[2] = '{3, -1, 1, -5, -2, 32'h1, 32'hFFFF_FFFB};
    vecs[3] = '{0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0};
    vecs[4] = '{2, -1, 3, 3, 0, 32'h0, 32'h3};
    vecs[5] = '{3, 0, -5, -2, 1, 32'h2, 32'h1};
    vecs[6] = '{3, 1, -5, -5, -2, 32'h2, 32'hFFFF_FFFE};
    repeat (3) @(posedge clk);
    #1;
    check("rst_master_read", 32'(master_read), 0);
    check("rst_master_address", master_address, 0);
    check("rst_waitrequest", 32'(slave_waitrequest), 0);
    slave_address = REG_CTRL;
    #1 check("rst_best_idx", slave_readdata, 32'hFFFF_FFFF);
    slave_address = REG_BASE;
    #1 check("rst_best_score", slave_readdata, 0);
    slave_address = REG_COUNT;
    #1 check("rst_busy", slave_readdata, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      init_board(0, vecs[i].s0);
      init_board(1, vecs[i].s1);
      init_board(2, vecs[i].s2);
      run(vecs[i].n, vecs[i].col, 32'h0000_1000 + 32'(i * 256), idx, sc, cyc);
      check($sformatf("vec%0d_idx", i), idx, vecs[i].eidx);
      check($sformatf("vec%0d_score", i), sc, vecs[i].escore);
      if (vecs[i].n == 0) check("zero_boards_fast", 32'(cyc <= 3), 1);
    end
    cpu(1, 4'd7, 32'h1234_5678, rd, c);
    cpu(0, REG_CTRL, 0, rd, c);
    check("ignored_write_idx", rd, 32'h2);
    cpu(0, 4'd5, 0, rd, c);
    check("unmapped_read", rd, 0);
    for (int bi = 0; bi < 256; bi++) init_board(bi, bi == 255 ? 3 : 0);
    run(1000, 1, 32'h0, idx, sc, cyc);
    check("clamp_idx", idx, 32'd255);
    check("clamp_score", sc, 32'd3);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 4);
      col = cols[$urandom_range(0, 4)];
      r = $urandom();
      bs = k == 2 ? 32'hFFFF_FF80 : {r[31:2], 2'b00};
      for (int w = 0; w < n * 64; w++) begin
        c = $urandom_range(0, 20);
        mem[w] = c <= 16 ? 8'(c - 8) : c == 17 ? -8'sd128 : c == 18 ? 8'sd127 : 8'sd0;
      end
      model(n, col, eidx, esc);
      for (int m = 0; m < 2; m++) begin
        rnd_mode = m == 1;
        run(n, col, bs, idx, sc, cyc);
        check($sformatf("rand%0d_m%0d_idx", k, m), idx, eidx);
        check($sformatf("rand%0d_m%0d_score", k, m), sc, esc);
      end
    end
    rnd_mode = 0;
    init_board(0, 0);
    init_board(1, 3);
    init_board(2, 3);
    cpu(1, REG_BASE, 32'h0000_8000, rd, c);
    cpu(1, REG_COUNT, 32'd3, rd, c);
    cpu(1, REG_COLOUR, 32'd1, rd, c);
    cur_base = 32'h0000_8000;
    run_start = acc_cnt;
    cpu(1, REG_CTRL, 0, rd, c);
    for (int i = 0; i < LIMIT && acc_cnt - run_start < 80; i++) @(negedge clk);
    check("reach_board2", 32'(acc_cnt - run_start >= 80), 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    check("midrst_master_read", 32'(master_read), 0);
    slave_address = REG_COUNT;
    #1 check("midrst_busy", slave_readdata, 0);
    slave_address = REG_CTRL;
    #1 check("midrst_best_idx", slave_readdata, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (master_read) cnt++;
    end
    check("midrst_no_restart", 32'(cnt), 0);
    run(3, 1, 32'h0000_8000, idx, sc, cyc);
    check("midrst_rerun_idx", idx, 32'h1);
    check("midrst_rerun_score", sc, 32'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
